uart_rx_deser: RTL and testbench

- Receive-side serial-to-parallel stage of the UART. It sits between the synchronized serial input and the receiver FIFO.
- It samples `srx_i` on 16x baud ticks, assembles 5–8 data bits plus optional parity, and checks stop, parity and break.
- It pushes one 11-bit word per frame into the receiver FIFO: data in bits [10:3], error flags in bits [2:0].

---
 rtl/uart_pkg.sv | 37 +++
 rtl/uart_rx_deser.sv | 199 +++++++++++++++++++
 tb/tb_uart_rx_deser.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: deserializer states, LCR bit positions
// and the receiver FIFO word layout.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StPush,
    StWaitHigh
  } rx_state_e;

  // Line control register bit positions
  localparam int unsigned LCR_WLS_LSB = 0;
  localparam int unsigned LCR_WLS_MSB = 1;
  localparam int unsigned LCR_PEN     = 3;
  localparam int unsigned LCR_EPS     = 4;
  localparam int unsigned LCR_SP      = 5;

  // Receiver FIFO word fields; the FIFO ORs the error bits at the same positions
  localparam int unsigned DATA_MSB = 10;
  localparam int unsigned DATA_LSB = 3;
  localparam int unsigned BRK      = 2;
  localparam int unsigned PE       = 1;
  localparam int unsigned FE       = 0;

  function automatic logic [3:0] word_len(input logic [1:0] wls);
    return 4'd5 + {2'b00, wls};
  endfunction

  function automatic logic [7:0] data_mask(input logic [1:0] wls);
    return 8'hFF >> (2'd3 - wls);
  endfunction

endpackage

// File: rtl/uart_rx_deser.sv
// UART receive deserializer: samples srx_i on 16x ticks, assembles one frame and pushes
// {data, break, parity_err, framing_err} into the receiver FIFO.
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  wb_rst_ni,
  input  logic                  enable,
  input  logic                  srx_i,
  input  logic [7:0]            lcr,
  output logic [FIFO_WIDTH-1:0] rf_data_in,
  output logic                  rf_push,
  output logic                  rx_busy
);

  rx_state_e             state_q, state_d;
  logic [3:0]            tcnt_q, tcnt_d;
  logic [2:0]            bcnt_q, bcnt_d;
  logic [7:0]            shift_q, shift_d;
  logic [5:0]            lcr_q, lcr_d;
  logic                  par_bit_q, par_bit_d;
  logic                  pe_q, pe_d;
  logic                  fe_q, fe_d;
  logic                  brk_q, brk_d;
  logic [FIFO_WIDTH-1:0] rf_data_in_q, rf_data_in_d;
  logic                  rf_push_q, rf_push_d;

  logic [3:0]            tcnt_inc;
  logic                  last_bit;
  logic                  par_xor;
  logic                  par_exp;
  logic [FIFO_WIDTH-1:0] word;

  logic unused_lcr;
  assign unused_lcr = ^{lcr[7:6], lcr[2], lcr_q[2]};

  assign tcnt_inc = tcnt_q + 4'd1;
  // Last data bit index is wordlen-1, i.e. 4..7
  assign last_bit = (bcnt_q == {1'b1, lcr_q[LCR_WLS_MSB:LCR_WLS_LSB]});
  assign par_xor  = ^(shift_q & data_mask(lcr_q[LCR_WLS_MSB:LCR_WLS_LSB]));

  always_comb begin
    par_exp = 1'b0;
    if (lcr_q[LCR_SP]) begin
      par_exp = ~lcr_q[LCR_EPS];
    end else if (lcr_q[LCR_EPS]) begin
      par_exp = par_xor;
    end else begin
      par_exp = ~par_xor;
    end
  end

  always_comb begin
    word                    = '0;
    word[DATA_MSB:DATA_LSB] = shift_q;
    word[BRK]               = brk_q;
    word[PE]                = pe_q;
    word[FE]                = fe_q;
  end

  always_comb begin
    state_d      = state_q;
    tcnt_d       = tcnt_q;
    bcnt_d       = bcnt_q;
    shift_d      = shift_q;
    lcr_d        = lcr_q;
    par_bit_d    = par_bit_q;
    pe_d         = pe_q;
    fe_d         = fe_q;
    brk_d        = brk_q;
    rf_data_in_d = rf_data_in_q;
    rf_push_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (enable && !srx_i) begin
          lcr_d     = lcr[5:0];
          tcnt_d    = '0;
          bcnt_d    = '0;
          shift_d   = '0;
          par_bit_d = 1'b0;
          pe_d      = 1'b0;
          fe_d      = 1'b0;
          brk_d     = 1'b0;
          state_d   = StStart;
        end
      end

      StStart: begin
        if (enable) begin
          if (tcnt_q == 4'd7) begin
            // Midpoint of the start bit: a high line here was only a glitch
            if (srx_i) begin
              state_d = StIdle;
            end else begin
              tcnt_d  = '0;
              state_d = StData;
            end
          end else begin
            tcnt_d = tcnt_inc;
          end
        end
      end

      StData: begin
        if (enable) begin
          if (tcnt_q == 4'd15) begin
            shift_d[bcnt_q] = srx_i;
            tcnt_d          = '0;
            bcnt_d          = bcnt_q + 3'd1;
            if (last_bit) begin
              state_d = lcr_q[LCR_PEN] ? StParity : StStop;
            end
          end else begin
            tcnt_d = tcnt_inc;
          end
        end
      end

      StParity: begin
        if (enable) begin
          if (tcnt_q == 4'd15) begin
            par_bit_d = srx_i;
            pe_d      = srx_i ^ par_exp;
            tcnt_d    = '0;
            state_d   = StStop;
          end else begin
            tcnt_d = tcnt_inc;
          end
        end
      end

      StStop: begin
        if (enable) begin
          if (tcnt_q == 4'd15) begin
            fe_d    = ~srx_i;
            brk_d   = ~srx_i && (shift_q == 8'h00) && (!lcr_q[LCR_PEN] || !par_bit_q);
            tcnt_d  = '0;
            state_d = StPush;
          end else begin
            tcnt_d = tcnt_inc;
          end
        end
      end

      StPush: begin
        // Not tick-gated; a tick arriving here is consumed without sampling
        rf_push_d    = 1'b1;
        rf_data_in_d = word;
        state_d      = fe_q ? StWaitHigh : StIdle;
      end

      StWaitHigh: begin
        if (enable && srx_i) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!wb_rst_ni) begin
      state_q      <= StIdle;
      tcnt_q       <= '0;
      bcnt_q       <= '0;
      shift_q      <= '0;
      lcr_q        <= '0;
      par_bit_q    <= 1'b0;
      pe_q         <= 1'b0;
      fe_q         <= 1'b0;
      brk_q        <= 1'b0;
      rf_data_in_q <= '0;
      rf_push_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tcnt_q       <= tcnt_d;
      bcnt_q       <= bcnt_d;
      shift_q      <= shift_d;
      lcr_q        <= lcr_d;
      par_bit_q    <= par_bit_d;
      pe_q         <= pe_d;
      fe_q         <= fe_d;
      brk_q        <= brk_d;
      rf_data_in_q <= rf_data_in_d;
      rf_push_q    <= rf_push_d;
    end
  end

  assign rf_data_in = rf_data_in_q;
  assign rf_push    = rf_push_q;
  assign rx_busy    = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_deser.sv
// Bench for uart_rx_deser: table of frames checked through a push scoreboard, plus
// hand sequences for latency, start glitch, break and mid-frame reset.
module tb_uart_rx_deser;
  import uart_pkg::*;

  logic        clk       = 1'b0;
  logic        wb_rst_ni = 1'b0;
  logic        enable    = 1'b0;
  logic        srx_i     = 1'b1;
  logic [7:0]  lcr       = 8'h00;
  logic [10:0] rf_data_in;
  logic        rf_push;
  logic        rx_busy;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [10:0] sb_q[$];
  logic [10:0] exp_w;
  logic [1:0]  div = 2'd0;

  typedef struct {
    logic [7:0]  lcr;
    logic [7:0]  lcr_mid;
    logic [7:0]  data;
    logic        par_flip;
    logic        stop_bit;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[12];

  uart_rx_deser #(
    .FIFO_WIDTH(11)
  ) dut (
    .clk       (clk),
    .wb_rst_ni (wb_rst_ni),
    .enable    (enable),
    .srx_i     (srx_i),
    .lcr       (lcr),
    .rf_data_in(rf_data_in),
    .rf_push   (rf_push),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  // One 16x tick every four clocks, changed away from the active edge
  always @(negedge clk) begin
    div    = div + 2'd1;
    enable = (div == 2'd0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rf_push) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_push: got word 0x%0h, required no push", rf_data_in);
      end else begin
        exp_w = sb_q.pop_front();
        check("push_word", {21'd0, rf_data_in}, {21'd0, exp_w});
      end
    end
  end

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; ) begin
      @(posedge clk);
      if (enable) i++;
    end
    #1;
  endtask

  function automatic logic exp_par(input logic [7:0] l, input logic [7:0] d);
    logic [7:0] m;
    logic       x;
    m = 8'hFF >> (3'd3 - {1'b0, l[1:0]});
    x = ^(d & m);
    if (l[5]) return ~l[4];
    if (l[4]) return x;
    return ~x;
  endfunction

  task automatic send_frame(input vec_t v);
    int nb;
    nb  = int'(word_len(v.lcr[1:0]));
    lcr = v.lcr;
    sb_q.push_back(v.exp);
    srx_i = 1'b0;
    wait_ticks(16);
    lcr = v.lcr_mid;
    for (int i = 0; i < nb; i++) begin
      srx_i = v.data[i];
      wait_ticks(16);
    end
    if (v.lcr[3]) begin
      srx_i = exp_par(v.lcr, v.data) ^ v.par_flip;
      wait_ticks(16);
    end
    srx_i = v.stop_bit;
    wait_ticks(16);
    srx_i = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    //        lcr    lcr_mid data   flip  stop  expected word
    vecs[0]  = '{8'h03, 8'h03, 8'h55, 1'b0, 1'b1, 11'h2A8};
    vecs[1]  = '{8'h1A, 8'h1A, 8'h41, 1'b1, 1'b1, 11'h20A};
    vecs[2]  = '{8'h00, 8'h03, 8'h1F, 1'b0, 1'b1, 11'h0F8};
    vecs[3]  = '{8'h03, 8'h03, 8'hA5, 1'b0, 1'b1, 11'h528};
    vecs[4]  = '{8'h0B, 8'h0B, 8'h3C, 1'b0, 1'b1, 11'h1E0};
    vecs[5]  = '{8'h39, 8'h39, 8'h2A, 1'b0, 1'b1, 11'h150};
    vecs[6]  = '{8'h03, 8'h03, 8'h81, 1'b0, 1'b0, 11'h409};
    vecs[7]  = '{8'h1A, 8'h1A, 8'h00, 1'b0, 1'b0, 11'h005};
    vecs[8]  = '{8'h1B, 8'h1B, 8'hFF, 1'b0, 1'b1, 11'h7F8};
    vecs[9]  = '{8'h08, 8'h08, 8'h15, 1'b1, 1'b1, 11'h0AA};
    vecs[10] = '{8'h2B, 8'h2B, 8'h00, 1'b1, 1'b1, 11'h002};
    vecs[11] = '{8'h1B, 8'h1B, 8'h00, 1'b1, 1'b0, 11'h003};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_data", {21'd0, rf_data_in}, 32'h0);
    check("reset_push", {31'd0, rf_push}, 32'h0);
    check("reset_busy", {31'd0, rx_busy}, 32'h0);
    wb_rst_ni = 1'b1;
    wait_ticks(4);

    // 8N1 latency: stop sample 152 ticks after detect, push one clock later
    fork
      send_frame(vecs[0]);
      begin
        wait_ticks(20);
        check("busy_in_frame", {31'd0, rx_busy}, 32'h1);
        wait_ticks(133);
        check("push_not_early", {31'd0, rf_push}, 32'h0);
        @(posedge clk);
        #1;
        check("push_latency", {31'd0, rf_push}, 32'h1);
        check("push_latency_word", {21'd0, rf_data_in}, 32'h2A8);
      end
    join
    wait_ticks(4);

    // Start glitch: low for 4 ticks, back to idle at the midpoint tick
    lcr   = 8'h03;
    srx_i = 1'b0;
    wait_ticks(1);
    check("glitch_busy_detect", {31'd0, rx_busy}, 32'h1);
    wait_ticks(3);
    srx_i = 1'b1;
    wait_ticks(4);
    check("glitch_busy_pre_mid", {31'd0, rx_busy}, 32'h1);
    wait_ticks(1);
    check("glitch_idle_at_mid", {31'd0, rx_busy}, 32'h0);
    wait_ticks(4);

    for (int i = 0; i < 12; i++) begin
      send_frame(vecs[i]);
      wait_ticks(2);
    end

    // Break: line low for three 8N1 frame times yields a single push
    lcr = 8'h03;
    sb_q.push_back(11'h005);
    srx_i = 1'b0;
    wait_ticks(480);
    check("break_pushed_once", sb_q.size(), 32'h0);
    check("break_wait_high", {31'd0, rx_busy}, 32'h1);
    srx_i = 1'b1;
    wait_ticks(2);
    check("break_released", {31'd0, rx_busy}, 32'h0);
    send_frame(vecs[4]);
    wait_ticks(2);

    // Reset in the middle of the data bits discards the frame
    lcr   = 8'h03;
    srx_i = 1'b0;
    wait_ticks(40);
    @(negedge clk);
    wb_rst_ni = 1'b0;
    srx_i     = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_data", {21'd0, rf_data_in}, 32'h0);
    check("midreset_push", {31'd0, rf_push}, 32'h0);
    check("midreset_busy", {31'd0, rx_busy}, 32'h0);
    wb_rst_ni = 1'b1;
    wait_ticks(4);
    send_frame(vecs[3]);
    wait_ticks(8);

    check("all_pushes_seen", sb_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
